exec_stage: RTL and testbench
=============================

Name: exec_stage

Overview:
- Multi-cycle execute sequencer for the 16-bit CPU datapath.
- Sits on both sides of the 8x16 register file:
  - consumes the register file's combinational read output to fetch two operands;
  - runs them through a shifter and ALU;
  - writes the result back through the register file's write port.
- Accepts one operation at a time over a valid/ready handshake.
- Exposes result register C and status flags to the controller.

Parameters:
- DATA_W, 16, datapath width; must match the register file word width.
- REG_W, 3, register index width (8 registers).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  operation request
- req_ready  output  1  high only in IDLE
- req_op  input  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 MVN (~B)
- req_shift  input  2  B shift: 00 none, 01 LSL1, 10 LSR1 (msb<-0), 11 ASR1 (msb kept)
- req_rn  input  REG_W  operand A register
- req_rm  input  REG_W  operand B register
- req_rd  input  REG_W  destination register
- req_wb  input  1  1 = write result back; 0 = flags/C only (compare)
- rf_readnum  output  REG_W  to register file readnum
- rf_data_out  input  DATA_W  from register file data_out (combinational)
- rf_writenum  output  REG_W  to register file writenum
- rf_write  output  1  to register file write
- rf_data_in  output  DATA_W  to register file data_in
- c_out  output  DATA_W  result register C
- z_flag, n_flag, v_flag  output  1  status
- done  output  1  one-cycle pulse on completion

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on rst_n.
- Reset values:
  - state = IDLE;
  - A, B, C = 0; Z, N, V = 0;
  - rf_write = 0, done = 0, req_ready = 1;
  - latched request fields = 0;
  - rf_readnum and rf_writenum = 0.
- FSM: IDLE -> READ_A -> READ_B -> EXEC -> WB -> IDLE.
  - IDLE: req_ready = 1. On req_valid at a posedge, latch op/shift/rn/rm/rd/wb and go to READ_A. Request inputs are ignored in every other state.
  - READ_A: rf_readnum = rn. At the posedge, A <= rf_data_out.
  - READ_B: rf_readnum = rm. At the posedge, B <= rf_data_out.
  - EXEC (combinational path):
    - sh = shift(B);
    - ADD: A+sh; SUB: A-sh; AND: A&sh; MVN: ~sh.
    - At the posedge, C <= result.
  - Flags in EXEC: Z = (result == 0); N = result[15].
    - V for ADD = signed overflow: A[15] == sh[15] and result[15] != A[15].
    - V for SUB = A[15] != sh[15] and result[15] != A[15].
    - V = 0 for AND and MVN.
  - WB (all outputs combinational from state):
    - rf_writenum = rd; rf_data_in = C; rf_write = wb; done = 1.
    - Next state is IDLE.
- Latency: acceptance edge T. Done is high during the cycle after edge T+3. The register file captures C at edge T+4. Throughput is one operation per 5 cycles.
- rf_readnum outside READ_A/READ_B holds the last driven value. rf_writenum outside WB = 0. rf_write = 0 everywhere except WB.
- Widths:
  - Arithmetic is modulo 2^16; carry is discarded.
  - Shifts are by exactly one bit.
- rd equal to rn or rm is legal: both reads finish before the write.
- rn == rm is legal: A == B.
- req_valid held high through busy produces exactly one acceptance per IDLE visit.
- Reset mid-operation: rf_write and done drop immediately (asynchronous). No writeback occurs. The FSM restarts in IDLE with C and flags cleared.
- c_out and the flags hold their values between operations and are updated only at the EXEC edge.

Decomposition:
- Shared package exec_pkg holds:
  - ALU op encodings;
  - shift encodings;
  - the FSM state enum (IDLE, READ_A, READ_B, EXEC, WB);
  - DATA_W and REG_W defaults.
- One combinational sub-module, exec_alu, holds the shifter, ALU and flag generation. The top level keeps the FSM and the A/B/C/status registers.

Test Plan:
- ADD, registers preloaded R1=0x0007, R2=0x0003; request op=ADD shift=00 rn=1 rm=2 rd=3 wb=1:
  - done 4 cycles after acceptance; rf_write=1, writenum=3, data_in=0x000A;
  - next cycle R3=0x000A; Z=0 N=0 V=0.
- Compare, R1=R2=0x1234; op=SUB wb=0:
  - C=0x0000, Z=1 N=0 V=0;
  - rf_write never asserted; done still pulses.
- Overflow, R4=0x7FFF, R5=0x0001; ADD rd=4:
  - R4 becomes 0x8000; N=1 V=1 Z=0. Also confirms rd==rn.
- MVN with shift, R6=0x8004; op=MVN shift=ASR1 rm=6 rd=7:
  - C=~0xC002=0x3FFD; R7=0x3FFD; V=0.
  - Repeat with LSL1: C=~0x0008=0xFFF7, N=1.
- Busy and reset:
  - Hold req_valid high for 12 cycles: exactly 3 completions; req_ready low in non-IDLE states.
  - Then assert rst_n=0 during EXEC: rf_write, done and C go to 0 immediately; destination register unchanged; req_ready=1 after release.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared encodings and defaults for the execute sequencer.
// ALU op and shift codes, the FSM state type and the datapath/register-index widths.
package exec_pkg;

  localparam int unsigned DataWidth = 16;
  localparam int unsigned RegWidth  = 3;

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpAnd = 2'b10,
    OpMvn = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ShNone = 2'b00,
    ShLsl1 = 2'b01,
    ShLsr1 = 2'b10,
    ShAsr1 = 2'b11
  } shift_e;

  typedef enum logic [2:0] {
    StIdle,
    StReadA,
    StReadB,
    StExec,
    StWb
  } state_e;

endpackage

// File: rtl/exec_if.sv
// Request handshake, register-file port and status bundle of the execute stage.
// The slave modport is the stage; the master modport is the controller/register-file side.
interface exec_if #(
  parameter int unsigned DATA_W = exec_pkg::DataWidth,
  parameter int unsigned REG_W  = exec_pkg::RegWidth
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [1:0]        req_shift;
  logic [REG_W-1:0]  req_rn;
  logic [REG_W-1:0]  req_rm;
  logic [REG_W-1:0]  req_rd;
  logic              req_wb;
  logic [REG_W-1:0]  rf_readnum;
  logic [DATA_W-1:0] rf_data_out;
  logic [REG_W-1:0]  rf_writenum;
  logic              rf_write;
  logic [DATA_W-1:0] rf_data_in;
  logic [DATA_W-1:0] c_out;
  logic              z_flag;
  logic              n_flag;
  logic              v_flag;
  logic              done;

  modport slave (
    input  req_valid, req_op, req_shift, req_rn, req_rm, req_rd, req_wb, rf_data_out,
    output req_ready, rf_readnum, rf_writenum, rf_write, rf_data_in,
    output c_out, z_flag, n_flag, v_flag, done
  );

  modport master (
    output req_valid, req_op, req_shift, req_rn, req_rm, req_rd, req_wb, rf_data_out,
    input  req_ready, rf_readnum, rf_writenum, rf_write, rf_data_in,
    input  c_out, z_flag, n_flag, v_flag, done
  );
endinterface

// File: rtl/exec_alu.sv
// Combinational one-bit shifter on B, ALU and status-flag generation.
// Carry is discarded; V is signed overflow for ADD/SUB and zero otherwise.
module exec_alu import exec_pkg::*; #(
  parameter int unsigned DATA_W = DataWidth
) (
  input  alu_op_e           op,
  input  shift_e            shift,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              n,
  output logic              v
);
  localparam int unsigned Msb = DATA_W - 1;

  logic [DATA_W-1:0] sh;

  always_comb begin
    sh = b;
    case (shift)
      ShLsl1:  sh = {b[Msb-1:0], 1'b0};
      ShLsr1:  sh = {1'b0, b[Msb:1]};
      ShAsr1:  sh = {b[Msb], b[Msb:1]};
      default: sh = b;
    endcase
  end

  always_comb begin
    result = '0;
    v      = 1'b0;
    case (op)
      OpAdd: begin
        result = a + sh;
        v      = (a[Msb] == sh[Msb]) && (result[Msb] != a[Msb]);
      end
      OpSub: begin
        result = a - sh;
        v      = (a[Msb] != sh[Msb]) && (result[Msb] != a[Msb]);
      end
      OpAnd:   result = a & sh;
      default: result = ~sh;
    endcase
    z = (result == '0);
    n = result[Msb];
  end

endmodule

// File: rtl/exec_stage.sv
// Multi-cycle execute sequencer: reads two operands from the register file, runs the ALU,
// and writes C back, one operation per five cycles (IDLE, READ_A, READ_B, EXEC, WB).
module exec_stage import exec_pkg::*; #(
  parameter int unsigned DATA_W = DataWidth,
  parameter int unsigned REG_W  = RegWidth
) (
  input  logic  clk,
  input  logic  rst_n,
  exec_if.slave bus
);
  state_e            state_q, state_d;
  alu_op_e           op_q;
  shift_e            shift_q;
  logic [REG_W-1:0]  rm_q, rd_q, readnum_q;
  logic              wb_q;
  logic [DATA_W-1:0] a_q, b_q, c_q;
  logic              z_q, n_q, v_q;

  logic [DATA_W-1:0] alu_result;
  logic              alu_z, alu_n, alu_v;

  logic              req_ready;
  logic              rf_write;
  logic              done;
  logic [REG_W-1:0]  rf_writenum;

  exec_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op_q),
    .shift  (shift_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .z      (alu_z),
    .n      (alu_n),
    .v      (alu_v)
  );

  // readnum is registered so it holds its last value outside the two read states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= OpAdd;
      shift_q   <= ShNone;
      rm_q      <= '0;
      rd_q      <= '0;
      wb_q      <= 1'b0;
      readnum_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      v_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            op_q      <= alu_op_e'(bus.req_op);
            shift_q   <= shift_e'(bus.req_shift);
            rm_q      <= bus.req_rm;
            rd_q      <= bus.req_rd;
            wb_q      <= bus.req_wb;
            readnum_q <= bus.req_rn;
          end
        end
        StReadA: begin
          a_q       <= bus.rf_data_out;
          readnum_q <= rm_q;
        end
        StReadB: b_q <= bus.rf_data_out;
        StExec: begin
          c_q <= alu_result;
          z_q <= alu_z;
          n_q <= alu_n;
          v_q <= alu_v;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state alone so an asynchronous reset drops write/done at once.
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    rf_write    = 1'b0;
    done        = 1'b0;
    rf_writenum = '0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (bus.req_valid) state_d = StReadA;
      end
      StReadA: state_d = StReadB;
      StReadB: state_d = StExec;
      StExec:  state_d = StWb;
      StWb: begin
        rf_write    = wb_q;
        done        = 1'b1;
        rf_writenum = rd_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.req_ready   = req_ready;
  assign bus.rf_readnum  = readnum_q;
  assign bus.rf_writenum = rf_writenum;
  assign bus.rf_write    = rf_write;
  assign bus.rf_data_in  = c_q;
  assign bus.c_out       = c_q;
  assign bus.z_flag      = z_q;
  assign bus.n_flag      = n_q;
  assign bus.v_flag      = v_q;
  assign bus.done        = done;

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: behavioural register-file/ALU model, per-cycle compare,
// directed literal cases, randomized operations, busy hold and mid-operation resets.
module tb_exec_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exec_if #(.DATA_W(16), .REG_W(3)) bus ();

  exec_stage #(
    .DATA_W (16),
    .REG_W  (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Register file environment: combinational read, write on rising edge, tb preload port.
  logic [15:0] rf [8];
  logic        pl_en = 1'b0;
  logic [2:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;
  assign bus.rf_data_out = rf[bus.rf_readnum];
  always @(posedge clk) begin
    if (bus.rf_write) rf[bus.rf_writenum] <= bus.rf_data_in;
    else if (pl_en) rf[pl_addr] <= pl_data;
  end

  // Behavioural model: cycles since acceptance, issued fields, predicted C/flags/register file.
  int          m_phase = 0;
  logic [1:0]  m_op = '0, m_sh = '0;
  logic [2:0]  m_rn = '0, m_rm = '0, m_rd = '0, m_readnum = '0;
  logic        m_wb = 1'b0;
  logic [15:0] m_rf [8];
  logic [15:0] m_c = '0;
  logic        m_z = 1'b0, m_n = 1'b0, m_v = 1'b0;

  int n_pass = 0;
  int n_checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Returns {v, n, z, result} from plain signed integer arithmetic.
  function automatic logic [18:0] ref_alu(input logic [1:0] op, input logic [1:0] sh,
                                          input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s, res;
    int sa, ss, r;
    logic v;
    case (sh)
      2'd0:    s = b;
      2'd1:    s = b << 1;
      2'd2:    s = b >> 1;
      default: s = $signed(b) >>> 1;
    endcase
    sa = int'($signed(a));
    ss = int'($signed(s));
    v = 1'b0;
    r = 0;
    res = '0;
    case (op)
      2'd0: begin r = sa + ss; v = (r > 32767) || (r < -32768); res = r[15:0]; end
      2'd1: begin r = sa - ss; v = (r > 32767) || (r < -32768); res = r[15:0]; end
      2'd2: res = a & s;
      default: res = ~s;
    endcase
    return {v, res[15], (res == 16'd0), res};
  endfunction

  task automatic model_edge();
    logic [18:0] out;
    if (!rst_n) return;
    if (pl_en) m_rf[pl_addr] = pl_data;
    case (m_phase)
      0: if (bus.req_valid) begin
        m_op = bus.req_op; m_sh = bus.req_shift; m_rn = bus.req_rn; m_rm = bus.req_rm;
        m_rd = bus.req_rd; m_wb = bus.req_wb; m_readnum = bus.req_rn; m_phase = 1;
      end
      1: begin m_readnum = m_rm; m_phase = 2; end
      2: m_phase = 3;
      3: begin
        out = ref_alu(m_op, m_sh, m_rf[m_rn], m_rf[m_rm]);
        {m_v, m_n, m_z, m_c} = out;
        m_phase = 4;
      end
      default: begin
        if (m_wb) m_rf[m_rd] = m_c;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic model_reset();
    m_phase = 0; m_c = '0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0; m_readnum = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", bus.req_ready, m_phase == 0);
      check("done", bus.done, m_phase == 4);
      check("rf_write", bus.rf_write, (m_phase == 4) && m_wb);
      check("rf_writenum", bus.rf_writenum, (m_phase == 4) ? m_rd : 3'd0);
      check("rf_readnum", bus.rf_readnum, m_readnum);
      check("c_out", bus.c_out, m_c);
      check("flags_znv", {bus.z_flag, bus.n_flag, bus.v_flag}, {m_z, m_n, m_v});
      if (m_phase == 4) check("rf_data_in", bus.rf_data_in, m_c);
      for (int i = 0; i < 8; i++) check($sformatf("rf[%0d]", i), rf[i], m_rf[i]);
    end
  end

  task automatic preload(input logic [2:0] addr, input logic [15:0] data);
    pl_en = 1'b1; pl_addr = addr; pl_data = data;
    tick();
    pl_en = 1'b0;
  endtask

  // Issues one request and returns at the falling edge inside WB.
  task automatic issue(input logic [1:0] op, input logic [1:0] sh, input logic [2:0] rn,
                       input logic [2:0] rm, input logic [2:0] rd, input logic wb);
    for (int i = 0; i < 20 && !bus.req_ready; i++) tick();
    check("ready_wait", bus.req_ready, 1);
    bus.req_op = op; bus.req_shift = sh; bus.req_rn = rn; bus.req_rm = rm;
    bus.req_rd = rd; bus.req_wb = wb; bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.req_op = 2'($urandom); bus.req_shift = 2'($urandom); bus.req_rn = 3'($urandom);
    bus.req_rm = 3'($urandom); bus.req_rd = 3'($urandom); bus.req_wb = 1'($urandom);
    repeat (3) tick();
  endtask

  function automatic logic [15:0] pick_data();
    logic [15:0] corner [4];
    corner = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
    if ($urandom_range(0, 2) == 0) return corner[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  initial begin
    int dones;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_shift = '0; bus.req_rn = '0;
    bus.req_rm = '0; bus.req_rd = '0; bus.req_wb = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_rf_write", bus.rf_write, 0);
    check("rst_c_out", bus.c_out, 16'h0000);
    check("rst_flags", {bus.z_flag, bus.n_flag, bus.v_flag}, 3'b000);
    check("rst_readnum", bus.rf_readnum, 0);
    check("rst_writenum", bus.rf_writenum, 0);
    rst_n = 1'b1;
    for (int r = 0; r < 8; r++) preload(3'(r), 16'($urandom));
    chk_en = 1'b1;

    // ADD R3 = R1 + R2
    preload(3'd1, 16'h0007); preload(3'd2, 16'h0003);
    issue(2'b00, 2'b00, 3'd1, 3'd2, 3'd3, 1'b1);
    check("add_done", bus.done, 1);
    check("add_rf_write", bus.rf_write, 1);
    check("add_writenum", bus.rf_writenum, 3);
    check("add_data_in", bus.rf_data_in, 16'h000A);
    tick();
    check("add_r3", rf[3], 16'h000A);
    check("add_flags", {bus.z_flag, bus.n_flag, bus.v_flag}, 3'b000);

    // Compare: SUB without writeback
    preload(3'd1, 16'h1234); preload(3'd2, 16'h1234);
    issue(2'b01, 2'b00, 3'd1, 3'd2, 3'd3, 1'b0);
    check("cmp_done", bus.done, 1);
    check("cmp_rf_write", bus.rf_write, 0);
    check("cmp_c_out", bus.c_out, 16'h0000);
    tick();
    check("cmp_flags", {bus.z_flag, bus.n_flag, bus.v_flag}, 3'b100);
    check("cmp_r3_kept", rf[3], 16'h000A);

    // Signed overflow with rd == rn
    preload(3'd4, 16'h7FFF); preload(3'd5, 16'h0001);
    issue(2'b00, 2'b00, 3'd4, 3'd5, 3'd4, 1'b1);
    tick();
    check("ovf_r4", rf[4], 16'h8000);
    check("ovf_flags", {bus.z_flag, bus.n_flag, bus.v_flag}, 3'b011);

    // MVN of shifted B
    preload(3'd6, 16'h8004);
    issue(2'b11, 2'b11, 3'd0, 3'd6, 3'd7, 1'b1);
    check("mvn_asr_c", bus.c_out, 16'h3FFD);
    tick();
    check("mvn_asr_r7", rf[7], 16'h3FFD);
    check("mvn_asr_flags", {bus.z_flag, bus.n_flag, bus.v_flag}, 3'b000);
    issue(2'b11, 2'b01, 3'd0, 3'd6, 3'd7, 1'b1);
    check("mvn_lsl_c", bus.c_out, 16'hFFF7);
    tick();
    check("mvn_lsl_flags", {bus.z_flag, bus.n_flag, bus.v_flag}, 3'b010);

    // Randomized operations
    repeat (40) begin
      if ($urandom_range(0, 2) == 0) preload(3'($urandom), pick_data());
      issue(2'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
            1'($urandom));
      tick();
      repeat ($urandom_range(0, 2)) tick();
    end

    // req_valid held high with changing fields: one acceptance per IDLE visit
    dones = 0;
    bus.req_valid = 1'b1;
    repeat (12) begin
      bus.req_op = 2'($urandom); bus.req_shift = 2'($urandom); bus.req_rn = 3'($urandom);
      bus.req_rm = 3'($urandom); bus.req_rd = 3'($urandom); bus.req_wb = 1'($urandom);
      tick();
      if (bus.done) dones++;
    end
    bus.req_valid = 1'b0;
    repeat (6) begin
      tick();
      if (bus.done) dones++;
    end
    check("busy_completions", dones, 3);

    // Reset during EXEC
    preload(3'd1, 16'h1111); preload(3'd2, 16'h2222); preload(3'd7, 16'h5A5A);
    issue(2'b00, 2'b00, 3'd1, 3'd2, 3'd0, 1'b1);
    tick();
    preload(3'd7, 16'h5A5A);
    bus.req_op = 2'b00; bus.req_shift = 2'b00; bus.req_rn = 3'd1; bus.req_rm = 3'd2;
    bus.req_rd = 3'd7; bus.req_wb = 1'b1; bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    repeat (2) tick();
    #2;
    check("exec_c_before_rst", bus.c_out, 16'h3333);
    rst_n = 1'b0; model_reset();
    #1;
    check("exec_rst_done", bus.done, 0);
    check("exec_rst_rf_write", bus.rf_write, 0);
    check("exec_rst_c", bus.c_out, 16'h0000);
    repeat (2) tick();
    #2 rst_n = 1'b1;
    tick();
    check("exec_rst_r7", rf[7], 16'h5A5A);
    check("exec_rst_ready", bus.req_ready, 1);

    // Reset during WB: done and write must drop at once, no writeback
    issue(2'b10, 2'b00, 3'd1, 3'd2, 3'd7, 1'b1);
    check("wb_done_before_rst", bus.done, 1);
    #2;
    rst_n = 1'b0; model_reset();
    #1;
    check("wb_rst_done", bus.done, 0);
    check("wb_rst_rf_write", bus.rf_write, 0);
    check("wb_rst_c", bus.c_out, 16'h0000);
    repeat (2) tick();
    #2 rst_n = 1'b1;
    tick();
    check("wb_rst_r7", rf[7], 16'h5A5A);
    check("wb_rst_ready", bus.req_ready, 1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
